// File: rtl/rgbw_fade_ctrl_pkg.sv
// rgbw_fade_ctrl shared types and constants.
// FSM encoding, duty width and prescaler width helper.
package rgbw_fade_ctrl_pkg;

  localparam int DUTY_W = 8;
  localparam int N_CH   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FADE   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // STEP_DIV=1 still needs a 1-bit counter
  function automatic int presc_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/rgbw_fade_ctrl_fade_step_unit.sv
// fade_step_unit: one channel's saturating step toward target.
// Ports: cur, tgt, step in; next out (combinational).
module fade_step_unit
  import rgbw_fade_ctrl_pkg::*;
(
  input  logic [DUTY_W-1:0] cur,
  input  logic [DUTY_W-1:0] tgt,
  input  logic [DUTY_W-1:0] step,
  output logic [DUTY_W-1:0] next
);

  logic [DUTY_W-1:0] gap;

  // gap is only used on the side where it is
  // non-negative, so cur+step / cur-step can
  // never leave 0..255 when gap > step.
  always_comb begin
    next = cur;
    gap  = '0;
    if (cur < tgt) begin
      gap  = tgt - cur;
      next = (gap > step) ? cur + step : tgt;
    end else if (cur > tgt) begin
      gap  = cur - tgt;
      next = (gap > step) ? cur - step : tgt;
    end
  end

endmodule

// File: rtl/rgbw_fade_ctrl.sv
// rgbw_fade_ctrl: linear RGBW duty fader for the PWM generator.
// Ports: clk, reset, ce, tgt0..3/tgt_valid/tgt_ready, abort,
//        duty0..3 (registered), busy, done (1-cycle pulse).
module rgbw_fade_ctrl
  import rgbw_fade_ctrl_pkg::*;
#(
  parameter int STEP_DIV  = 256,
  parameter int STEP_SIZE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [DUTY_W-1:0] tgt0,
  input  logic [DUTY_W-1:0] tgt1,
  input  logic [DUTY_W-1:0] tgt2,
  input  logic [DUTY_W-1:0] tgt3,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty0,
  output logic [DUTY_W-1:0] duty1,
  output logic [DUTY_W-1:0] duty2,
  output logic [DUTY_W-1:0] duty3,
  output logic              busy,
  output logic              done
);

  localparam int PW = presc_w(STEP_DIV);
  localparam logic [PW-1:0] PMAX =
    PW'(STEP_DIV - 1);
  localparam logic [DUTY_W-1:0] STEP =
    DUTY_W'(STEP_SIZE);

  state_t state, state_nx;

  logic [PW-1:0]     presc;
  logic [DUTY_W-1:0] cur   [N_CH];
  logic [DUTY_W-1:0] tgt_q [N_CH];
  logic [DUTY_W-1:0] tgt_in[N_CH];
  logic [DUTY_W-1:0] nxt   [N_CH];

  logic tick;
  logic load;
  logic step_en;
  logic match_in;
  logic arrive;

  assign tgt_in[0] = tgt0;
  assign tgt_in[1] = tgt1;
  assign tgt_in[2] = tgt2;
  assign tgt_in[3] = tgt3;

  assign duty0 = cur[0];
  assign duty1 = cur[1];
  assign duty2 = cur[2];
  assign duty3 = cur[3];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    fade_step_unit u_step (
      .cur  (cur[i]),
      .tgt  (tgt_q[i]),
      .step (STEP),
      .next (nxt[i])
    );
  end

  assign tick = ce && (presc == PMAX);

  // match_in: incoming set equals current duties
  // arrive:   the pending step lands every channel
  always_comb begin
    match_in = 1'b1;
    arrive   = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (tgt_in[i] != cur[i]) match_in = 1'b0;
      if (nxt[i] != tgt_q[i])  arrive   = 1'b0;
    end
  end

  always_comb begin
    state_nx  = state;
    tgt_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    step_en   = 1'b0;
    unique case (state)
      IDLE: begin
        tgt_ready = 1'b1;
        if (tgt_valid) begin
          load     = 1'b1;
          state_nx = match_in ? FINISH : FADE;
        end
      end
      FADE: begin
        busy = 1'b1;
        // abort wins over a coincident tick
        if (abort) begin
          state_nx = FINISH;
        end else if (tick) begin
          step_en = 1'b1;
          if (arrive) state_nx = FINISH;
        end
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cur[i]   <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (load) begin
        presc <= '0;
        for (int i = 0; i < N_CH; i++)
          tgt_q[i] <= tgt_in[i];
      end else if (busy && ce) begin
        presc <= tick ? '0 : presc + PW'(1);
      end
      if (step_en) begin
        for (int i = 0; i < N_CH; i++)
          cur[i] <= nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_rgbw_fade_ctrl.sv
// tb_rgbw_fade_ctrl: two DUTs (STEP_SIZE 1 and 16, STEP_DIV 4)
// checked against closed-form ramp predictions.
module tb_rgbw_fade_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst   [2];
  logic       ce    [2];
  logic       valid [2];
  logic       abrt  [2];
  logic [7:0] tgt   [2][4];
  logic [7:0] duty  [2][4];
  logic       rdy   [2];
  logic       busy  [2];
  logic       done  [2];

  int tests = 0;
  int fails = 0;
  int exp_d [2][4];
  int last_n;
  logic [31:0] snap1, snap3;

  always #5 clk = ~clk;

  rgbw_fade_ctrl #(.STEP_DIV(DIV), .STEP_SIZE(1)) dut0 (
    .clk(clk), .reset(rst[0]), .ce(ce[0]),
    .tgt0(tgt[0][0]), .tgt1(tgt[0][1]),
    .tgt2(tgt[0][2]), .tgt3(tgt[0][3]),
    .tgt_valid(valid[0]), .tgt_ready(rdy[0]),
    .abort(abrt[0]),
    .duty0(duty[0][0]), .duty1(duty[0][1]),
    .duty2(duty[0][2]), .duty3(duty[0][3]),
    .busy(busy[0]), .done(done[0])
  );

  rgbw_fade_ctrl #(.STEP_DIV(DIV), .STEP_SIZE(16)) dut1 (
    .clk(clk), .reset(rst[1]), .ce(ce[1]),
    .tgt0(tgt[1][0]), .tgt1(tgt[1][1]),
    .tgt2(tgt[1][2]), .tgt3(tgt[1][3]),
    .tgt_valid(valid[1]), .tgt_ready(rdy[1]),
    .abort(abrt[1]),
    .duty0(duty[1][0]), .duty1(duty[1][1]),
    .duty2(duty[1][2]), .duty3(duty[1][3]),
    .busy(busy[1]), .done(done[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack(input int a[4]);
    return {8'(a[0]), 8'(a[1]), 8'(a[2]), 8'(a[3])};
  endfunction

  function automatic logic [31:0] obs(input int idx);
    return {duty[idx][0], duty[idx][1],
            duty[idx][2], duty[idx][3]};
  endfunction

  // duty after k steps of size sz from s toward t
  function automatic int ramp(input int s, input int t,
                              input int k, input int sz);
    if (t >= s)
      return s + ((k * sz < t - s) ? k * sz : t - s);
    return s - ((k * sz < s - t) ? k * sz : s - t);
  endfunction

  task automatic fade(input int idx, input int t[4]);
    int s[4];
    int e[4];
    int maxd, d, n, sz;
    sz   = (idx == 1) ? 16 : 1;
    s    = exp_d[idx];
    maxd = 0;
    for (int c = 0; c < 4; c++) begin
      d = (t[c] > s[c]) ? t[c] - s[c] : s[c] - t[c];
      if (d > maxd) maxd = d;
    end
    n = (maxd + sz - 1) / sz;
    last_n = n;
    chk("rdy_before", rdy[idx], 1);
    for (int c = 0; c < 4; c++) tgt[idx][c] = 8'(t[c]);
    valid[idx] = 1'b1;
    cyc();
    valid[idx] = 1'b0;
    if (n == 0) begin
      chk("null_done", done[idx], 1);
      chk("null_busy", busy[idx], 0);
      chk("null_duty", obs(idx), pack(s));
      cyc();
      chk("null_done_off", done[idx], 0);
      chk("null_rdy", rdy[idx], 1);
      return;
    end
    chk("busy_rise", busy[idx], 1);
    chk("rdy_low", rdy[idx], 0);
    for (int k = 1; k <= n; k++) begin
      repeat (DIV - 1) cyc();
      for (int c = 0; c < 4; c++)
        e[c] = ramp(s[c], t[c], k - 1, sz);
      chk("hold", obs(idx), pack(e));
      cyc();
      for (int c = 0; c < 4; c++)
        e[c] = ramp(s[c], t[c], k, sz);
      chk("step", obs(idx), pack(e));
      if (k == 1) snap1 = obs(idx);
      if (k == 3) snap3 = obs(idx);
      if (k < n) chk("busy_mid", busy[idx], 1);
    end
    chk("done_pulse", done[idx], 1);
    chk("busy_fall", busy[idx], 0);
    chk("rdy_finish", rdy[idx], 0);
    cyc();
    chk("done_once", done[idx], 0);
    chk("rdy_back", rdy[idx], 1);
    exp_d[idx] = t;
  endtask

  initial begin
    int t[4];
    int z[4];
    z = '{0, 0, 0, 0};
    for (int i = 0; i < 2; i++) begin
      rst[i]   = 1'b1;
      ce[i]    = 1'b1;
      valid[i] = 1'b0;
      abrt[i]  = 1'b0;
      exp_d[i] = z;
      for (int c = 0; c < 4; c++) tgt[i][c] = 8'd0;
    end
    #1;
    cyc();
    cyc();
    for (int i = 0; i < 2; i++) begin
      chk("rst_duty", obs(i), 32'd0);
      chk("rst_busy", busy[i], 0);
      chk("rst_done", done[i], 0);
      chk("rst_rdy", rdy[i], 1);
      rst[i] = 1'b0;
    end

    fade(0, '{3, 0, 0, 0});
    fade(0, '{3, 0, 0, 0});

    fade(1, '{3, 0, 0, 0});
    fade(1, '{0, 40, 255, 3});
    chk("mix_step1", snap1, {8'd0, 8'd16, 8'd16, 8'd3});
    chk("mix_ch1_s3", {24'd0, snap3[23:16]}, 32'd40);
    chk("mix_nsteps", last_n, 16);

    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++)
        t[c] = int'($urandom_range(0, 60));
      fade(0, t);
      for (int c = 0; c < 4; c++)
        t[c] = int'($urandom_range(0, 255));
      fade(1, t);
    end
    fade(1, exp_d[1]);

    rst[0] = 1'b1;
    cyc();
    rst[0] = 1'b0;
    exp_d[0] = z;
    chk("rst2_duty", obs(0), 32'd0);

    tgt[0][0] = 8'd200;
    tgt[0][1] = 8'd0;
    tgt[0][2] = 8'd0;
    tgt[0][3] = 8'd0;
    valid[0] = 1'b1;
    cyc();
    valid[0] = 1'b0;
    repeat (5 * DIV) cyc();
    chk("ab_5steps", obs(0), {8'd5, 24'd0});
    repeat (2) cyc();
    ce[0] = 1'b0;
    repeat (20) cyc();
    chk("freeze_duty", obs(0), {8'd5, 24'd0});
    chk("freeze_busy", busy[0], 1);
    ce[0] = 1'b1;
    cyc();
    chk("pre_tick", obs(0), {8'd5, 24'd0});
    abrt[0] = 1'b1;
    cyc();
    abrt[0] = 1'b0;
    chk("abort_duty", obs(0), {8'd5, 24'd0});
    chk("abort_done", done[0], 1);
    chk("abort_busy", busy[0], 0);
    cyc();
    chk("abort_idle", rdy[0], 1);
    chk("abort_done_off", done[0], 0);
    abrt[0] = 1'b1;
    cyc();
    abrt[0] = 1'b0;
    chk("abort_idle_nop", {30'd0, rdy[0], done[0]}, 32'd2);

    valid[0] = 1'b1;
    cyc();
    tgt[0][0] = 8'd0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("retgt_rdy", rdy[0], 0);
      chk("retgt_busy", busy[0], 1);
      chk("retgt_duty", obs(0), {8'd5, 24'd0});
    end
    valid[0] = 1'b0;
    rst[0] = 1'b1;
    cyc();
    rst[0] = 1'b0;
    chk("rstmid_duty", obs(0), 32'd0);
    chk("rstmid_busy", busy[0], 0);
    chk("rstmid_done", done[0], 0);
    chk("rstmid_rdy", rdy[0], 1);
    cyc();
    chk("rstmid_nodone", done[0], 0);
    exp_d[0] = z;

    fade(0, '{2, 1, 0, 4});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
